instr_fetch_master: RTL and testbench
=====================================

INSTR_FETCH_MASTER -- requirements
Module: instr_fetch_master

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first fetch byte address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (legal: 2..8).
REQ-003 SHALL use one clock and a synchronous active-high reset; no other clock or reset inputs.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 fetch_en_i  input  1  permit new memory requests.
REQ-007 redirect_i  input  1  single-cycle branch/jump redirect strobe.
REQ-008 redirect_pc_i  input  32  redirect target byte address.
REQ-009 req_o  output  1  memory request strobe.
REQ-010 addr_o  output  12  memory word address (pc[13:2]).
REQ-011 we_o  output  1  write enable, constant 0.
REQ-012 wmask_o  output  4  write mask, constant 4'hF.
REQ-013 wdata_o  output  32  write data, constant 0.
REQ-014 rdata_i  input  32  memory read data, qualified by rvalid_i.
REQ-015 rvalid_i  input  1  read response, exactly one cycle after an accepted read req.
REQ-016 instr_valid_o  output  1  buffered instruction available.
REQ-017 instr_ready_i  input  1  consumer accepts instruction.
REQ-018 instr_rdata_o  output  32  instruction word at FIFO head.
REQ-019 instr_pc_o  output  32  byte address of instr_rdata_o.

Function
REQ-020 States: IDLE (fetch_en_i low), RUN (issuing), REDIR (one-cycle restart after redirect).
REQ-021 IDLE->RUN when fetch_en_i=1; RUN->IDLE when fetch_en_i=0; any state->REDIR on redirect_i=1; REDIR->RUN if fetch_en_i=1 else IDLE.
REQ-022 req_o SHALL assert in RUN only when (count + inflight - pop) < FIFO_DEPTH, where pop = instr_valid_o & instr_ready_i (combinational ready->req path allowed).
REQ-023 Each issued req SHALL present addr_o = pc[13:2]; pc SHALL advance by 4 in the same cycle, wrapping 32'hFFFF_FFFC -> 0; addr_o wraps 12'hFFF -> 12'h000.
REQ-024 inflight SHALL set on issue and clear on rvalid_i; the issued pc SHALL be held as inflight_pc.
REQ-025 rvalid_i with inflight=1 and drop=0 SHALL push {inflight_pc, rdata_i} into the FIFO; sustained throughput one instruction/cycle with instr_ready_i held high.
REQ-026 rvalid_i with inflight=0 SHALL be ignored.
REQ-027 redirect_i SHALL flush the FIFO that cycle, load pc = {redirect_pc_i[31:2],2'b00}, set drop if a request is inflight or issued that cycle, and suppress req_o that cycle.
REQ-028 A response arriving with drop=1 SHALL be discarded and drop cleared.
REQ-029 First post-redirect req_o SHALL occur in REDIR cycle (redirect cycle +1) when fetch_en_i=1.
REQ-030 Simultaneous redirect_i and pop: pop ignored; simultaneous push and pop on full FIFO: legal, count unchanged.
REQ-031 fetch_en_i deassert SHALL stop new requests only; an inflight response SHALL still be buffered and the FIFO SHALL drain.
REQ-032 instr_valid_o = (count != 0); outputs SHALL hold stable while instr_valid_o=1 and instr_ready_i=0.

Reset
REQ-033 On rst_i: state=IDLE, pc=BOOT_ADDR, count=0, inflight=0, drop=0, req_o=0, instr_valid_o=0, instr_rdata_o/instr_pc_o=0.
REQ-034 Reset mid-operation SHALL abandon any inflight request; its late rvalid_i SHALL be ignored per REQ-026.

Structure
REQ-035 Package instr_fetch_pkg SHALL hold the state enum (IDLE, RUN, REDIR) and fetch_entry_t struct {pc[31:0], instr[31:0]}.
REQ-036 Buffering SHALL be one sub-module fetch_fifo (synchronous, parameterised depth/entry type, flush input).

Verification
REQ-037 Reset, fetch_en_i=1, ready=1, memory word k = 32'h1000_0000+k -> req_o first cycle after reset release, addr_o 0,1,2,..., instr_pc_o 0,4,8 with matching data, one per cycle.
REQ-038 instr_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered, req_o low, no data lost on release.
REQ-039 redirect_i with redirect_pc_i=32'h0000_0103 while inflight -> inflight response dropped, next req addr_o=12'h040, instr_pc_o=32'h0000_0100.
REQ-040 BOOT_ADDR=32'h0000_3FFC -> addr_o 12'hFFF then 12'h000, instr_pc_o 32'h3FFC then 32'h4000.
REQ-041 rst_i asserted one cycle after req_o -> all outputs at reset values, stray rvalid_i ignored, fetch resumes at BOOT_ADDR.
REQ-042 Spurious rvalid_i with fetch_en_i=0 and FIFO empty -> instr_valid_o stays 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared types for the instruction fetch master and its buffer.
//   fetch_state_t : fetch controller states (IDLE, RUN, REDIR)
//   fetch_entry_t : one buffered instruction with its byte address
//   PC_STEP       : byte increment between sequential fetches
//   align_word()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched instructions until the consumer takes them.
// A push and a pop in the same cycle are accepted even when full.
// flush empties the buffer and overrides push/pop in that cycle.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   flush        : discard all entries
//   push         : write push_data (ignored when full without a pop)
//   push_data    : entry to write
//   pop          : remove the head entry (ignored when empty)
//   head_data    : entry at the head of the buffer
//   count        : number of valid entries
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [63:0],
    parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full buffer is only legal when the head leaves at the same time.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        pop_ok  = pop && (count != '0);
        push_ok = push && (!full || pop_ok);
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_master.sv
// ---------------------------------------------------------------------------
// instr_fetch_master
// Read-only memory master that fetches sequential instruction words, buffers
// them with their byte address and hands them to a ready/valid consumer.
// A redirect strobe flushes the buffer and restarts fetching at a new pc.
// Ports:
//   clk_i, rst_i       : clock and synchronous active-high reset
//   fetch_en_i         : permit new memory requests
//   redirect_i         : one-cycle branch/jump strobe
//   redirect_pc_i      : redirect target byte address
//   req_o, addr_o      : memory request strobe and word address (pc[13:2])
//   we_o, wmask_o,
//   wdata_o            : write side, tied to a read
//   rdata_i, rvalid_i  : memory response, one cycle after an accepted request
//   instr_valid_o      : buffered instruction available
//   instr_ready_i      : consumer takes the head instruction
//   instr_rdata_o      : head instruction word
//   instr_pc_o         : byte address of the head instruction
// ---------------------------------------------------------------------------
module instr_fetch_master
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        req_o,
    output logic [11:0] addr_o,
    output logic        we_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    input  logic        rvalid_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic             drop;
    logic             fetch_go;
    logic             pop;
    logic             push;
    logic [31:0]      occupancy;
    logic             has_room;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Every state may issue while enabled: IDLE issues on its way to RUN so a
    // start costs no bubble, and REDIR issues the first fetch at the new target.
    always_comb begin
        fetch_go = 1'b0;
        case (state)
            IDLE, RUN, REDIR: fetch_go = fetch_en_i;
            default:          fetch_go = 1'b0;
        endcase
    end

    // A request is only issued if its response is guaranteed a buffer slot,
    // counting the response still owed and the entry leaving this cycle.
    assign pop       = instr_valid_o & instr_ready_i & ~redirect_i;
    assign occupancy = 32'(fifo_count) + 32'(inflight) - 32'(pop);
    assign has_room  = occupancy < 32'(FIFO_DEPTH);
    assign req_o     = fetch_go & has_room & ~redirect_i & ~rst_i;
    assign addr_o    = pc[13:2];

    assign we_o    = 1'b0;
    assign wmask_o = 4'hF;
    assign wdata_o = 32'h0000_0000;

    // Responses with nothing owed (after reset) or marked stale are discarded.
    assign push       = rvalid_i & inflight & ~drop;
    assign push_entry = '{pc: inflight_pc, instr: rdata_i};

    // Controller state, fetch pointer and outstanding-response bookkeeping.
    // drop is only needed when the old response has not already arrived in the
    // redirect cycle itself; a response arriving then is removed by the flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pc          <= BOOT_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (fetch_en_i) state <= RUN;
                RUN:     if (!fetch_en_i) state <= IDLE;
                REDIR:   state <= fetch_en_i ? RUN : IDLE;
                default: state <= IDLE;
            endcase
            if (redirect_i) begin
                state <= REDIR;
            end

            if (redirect_i) begin
                pc <= align_word(redirect_pc_i);
            end else if (req_o) begin
                pc <= pc + PC_STEP;
            end

            if (req_o) begin
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else if (rvalid_i) begin
                inflight <= 1'b0;
            end

            if (redirect_i) begin
                drop <= inflight & ~rvalid_i;
            end else if (rvalid_i) begin
                drop <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fetch_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign instr_valid_o = (fifo_count != '0);
    assign instr_rdata_o = head_entry.instr;
    assign instr_pc_o    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_master.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_master
// Directed bench for instr_fetch_master. A queue-based model of the
// instruction stream predicts every output each cycle; literal expectations
// pin the model at key points. A second instance boots near the top of the
// 14-bit address window to exercise address wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch_master;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam logic [31:0] BOOT2 = 32'h0000_3FFC;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        req_o;
    logic [11:0] addr_o;
    logic        we_o;
    logic [3:0]  wmask_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_i;
    logic        rvalid_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;

    logic        req2;
    logic [11:0] addr2;
    logic        we2;
    logic [3:0]  wmask2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        rvalid2;
    logic        valid2;
    logic [31:0] instr_rdata2;
    logic [31:0] instr_pc2;

    always #5 clk_i = ~clk_i;

    instr_fetch_master #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .req_o         (req_o),
        .addr_o        (addr_o),
        .we_o          (we_o),
        .wmask_o       (wmask_o),
        .wdata_o       (wdata_o),
        .rdata_i       (rdata_i),
        .rvalid_i      (rvalid_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_o (instr_rdata_o),
        .instr_pc_o    (instr_pc_o)
    );

    instr_fetch_master #(
        .BOOT_ADDR  (BOOT2),
        .FIFO_DEPTH (DEPTH)
    ) dut_wrap (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .req_o         (req2),
        .addr_o        (addr2),
        .we_o          (we2),
        .wmask_o       (wmask2),
        .wdata_o       (wdata2),
        .rdata_i       (rdata2),
        .rvalid_i      (rvalid2),
        .instr_valid_o (valid2),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_o (instr_rdata2),
        .instr_pc_o    (instr_pc2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_entry_t;

    int          checks = 0;
    int          errors = 0;
    bit          check_en;

    // Model of the instruction stream: buffered entries, next fetch pc and
    // whether a response is owed for a request issued last cycle.
    exp_entry_t  mq[$];
    logic [31:0] m_pc;
    bit          m_owed;
    logic [31:0] m_owed_pc;

    // Memory responders for both instances.
    bit          mem_pend;
    logic [11:0] mem_addr;
    bit          mem2_pend;
    logic [11:0] mem2_addr;

    // Values sampled in the most recent cycle.
    logic        s_req;
    logic [11:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_data;
    logic [11:0] s2_addr;
    logic [31:0] s2_pc;
    logic [31:0] s2_data;

    function automatic logic [31:0] memWord(input logic [11:0] w);
        return 32'h1000_0000 + {20'h0, w};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs, compares every output against the model,
    // advances the model across the clock edge and records memory requests.
    task automatic applyStimulus(input logic rst, input logic fen, input logic redir,
                                 input logic [31:0] rpc, input logic ready, input logic spur);
        bit exp_valid;
        bit pop;
        bit exp_req;
        int occ;
        rst_i         = rst;
        fetch_en_i    = fen;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        instr_ready_i = ready;
        rvalid_i      = mem_pend | spur;
        rdata_i       = mem_pend ? memWord(mem_addr) : 32'hDEAD_BEEF;
        rvalid2       = mem2_pend;
        rdata2        = memWord(mem2_addr);
        #1;
        s_req   = req_o;
        s_addr  = addr_o;
        s_valid = instr_valid_o;
        s_pc    = instr_pc_o;
        s_data  = instr_rdata_o;
        s2_addr = addr2;
        s2_pc   = instr_pc2;
        s2_data = instr_rdata2;

        exp_valid = (mq.size() != 0);
        pop       = exp_valid && ready && !redir;
        occ       = mq.size() + (m_owed ? 1 : 0) - (pop ? 1 : 0);
        exp_req   = !rst && fen && !redir && (occ < DEPTH);

        if (check_en) begin
            checkOutput("req_o", {31'h0, s_req}, {31'h0, exp_req});
            if (exp_req) checkOutput("addr_o", {20'h0, s_addr}, {20'h0, m_pc[13:2]});
            checkOutput("instr_valid_o", {31'h0, s_valid}, {31'h0, exp_valid});
            if (exp_valid) begin
                checkOutput("instr_pc_o", s_pc, mq[0].pc);
                checkOutput("instr_rdata_o", s_data, mq[0].data);
            end
            checkOutput("we_o", {31'h0, we_o}, 32'h0);
            checkOutput("wmask_o", {28'h0, wmask_o}, 32'hF);
            checkOutput("wdata_o", wdata_o, 32'h0);
        end

        if (rst) begin
            mq.delete();
            m_pc   = BOOT;
            m_owed = 1'b0;
        end else begin
            if (redir) begin
                mq.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                if (pop) void'(mq.pop_front());
                if (m_owed && rvalid_i) begin
                    mq.push_back('{pc: m_owed_pc, data: memWord(m_owed_pc[13:2])});
                end
            end
            if (exp_req) begin
                m_owed_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_owed = exp_req;
        end

        mem_pend  = s_req;
        mem_addr  = s_addr;
        mem2_pend = req2;
        mem2_addr = s2_addr;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic runCycles(input int n, input logic fen, input logic ready);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, fen, 1'b0, 32'h0, ready, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i         = 1'b1;
        fetch_en_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        rvalid_i      = 1'b0;
        rdata_i       = 32'h0;
        rvalid2       = 1'b0;
        rdata2        = 32'h0;
        mem_pend      = 1'b0;
        mem_addr      = '0;
        mem2_pend     = 1'b0;
        mem2_addr     = '0;
        check_en      = 1'b0;
        m_pc          = BOOT;
        m_owed        = 1'b0;
        m_owed_pc     = '0;
        @(negedge clk_i);

        // Reset values, with fetch enabled while still in reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("reset req_o", {31'h0, s_req}, 32'h0);
        checkOutput("reset instr_valid_o", {31'h0, s_valid}, 32'h0);
        checkOutput("reset instr_pc_o", s_pc, 32'h0);
        checkOutput("reset instr_rdata_o", s_data, 32'h0);

        // Streaming from BOOT_ADDR, one instruction per cycle; wrap instance too.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            if (i == 0) begin
                checkOutput("first req_o", {31'h0, s_req}, 32'h1);
                checkOutput("first addr_o", {20'h0, s_addr}, 32'h0);
                checkOutput("wrap first addr_o", {20'h0, s2_addr}, 32'hFFF);
            end
            if (i == 1) checkOutput("wrap second addr_o", {20'h0, s2_addr}, 32'h000);
            if (i == 2) begin
                checkOutput("stream pc0", s_pc, 32'h0000_0000);
                checkOutput("stream data0", s_data, 32'h1000_0000);
                checkOutput("wrap pc0", s2_pc, 32'h0000_3FFC);
                checkOutput("wrap data0", s2_data, 32'h1000_0FFF);
            end
            if (i == 3) begin
                checkOutput("stream pc1", s_pc, 32'h0000_0004);
                checkOutput("stream data1", s_data, 32'h1000_0001);
                checkOutput("wrap pc1", s2_pc, 32'h0000_4000);
                checkOutput("wrap data1", s2_data, 32'h1000_0000);
            end
        end

        // Consumer stalls for 10 cycles: buffer fills, requests stop.
        runCycles(10, 1'b1, 1'b0);
        checkOutput("stall req_o", {31'h0, s_req}, 32'h0);
        checkOutput("stall instr_valid_o", {31'h0, s_valid}, 32'h1);
        checkOutput("stall head pc", s_pc, 32'h0000_0018);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("release req_o", {31'h0, s_req}, 32'h1);
        checkOutput("release addr_o", {20'h0, s_addr}, 32'h008);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("release next pc", s_pc, 32'h0000_001C);
        checkOutput("release next data", s_data, 32'h1000_0007);
        runCycles(2, 1'b1, 1'b1);

        // Redirect to an unaligned target while a request is outstanding.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
        checkOutput("redirect cycle req_o", {31'h0, s_req}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("restart req_o", {31'h0, s_req}, 32'h1);
        checkOutput("restart addr_o", {20'h0, s_addr}, 32'h040);
        checkOutput("flushed instr_valid_o", {31'h0, s_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("redirect head pc", s_pc, 32'h0000_0100);
        checkOutput("redirect head data", s_data, 32'h1000_0040);
        runCycles(4, 1'b1, 1'b1);

        // Disable fetch: outstanding response still buffered, then drained.
        runCycles(4, 1'b0, 1'b0);
        checkOutput("disabled req_o", {31'h0, s_req}, 32'h0);
        checkOutput("disabled instr_valid_o", {31'h0, s_valid}, 32'h1);
        runCycles(4, 1'b0, 1'b1);
        checkOutput("drained instr_valid_o", {31'h0, s_valid}, 32'h0);

        // Reset one cycle after a request, then stray responses.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("pre-reset req_o", {31'h0, s_req}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("post-reset instr_valid_o", {31'h0, s_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("stray rvalid ignored", {31'h0, s_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("resume req_o", {31'h0, s_req}, 32'h1);
        checkOutput("resume addr_o", {20'h0, s_addr}, 32'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("resume head pc", s_pc, 32'h0000_0000);
        checkOutput("resume head data", s_data, 32'h1000_0000);
        runCycles(3, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
